// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI receive deserializer. Synchronizes cs_L/sclk/data into the
// system clock domain, shifts MSB-first WIDTH-bit words on each sclk rise and
// hands completed words to a single-entry valid/ready output buffer.
// Optional feature macro: SPI_RX_FRAME_ERR_EN adds o_rx_frame_err, a one-clk
// pulse when chip select rises with a partially received word.
module spi_rx_deser #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_spi_cs_L,
  input  logic             i_spi_sclk,
  input  logic             i_spi_data,
  input  logic             i_rx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_rx_overrun,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic             o_rx_frame_err,
`endif
  output logic [4:0]       o_bit_count
);

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_data_sync;
  logic                   r_sclk_d;
  state_t                 r_state, w_state_nxt;
  logic [WIDTH-1:0]       r_sr;
  logic [4:0]             r_bit_cnt;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid, r_rx_overrun;

  logic             w_cs_s, w_sclk_s, w_data_s;
  logic             w_rise, w_shift_en, w_word_done, w_abort, w_accept;
  logic [WIDTH-1:0] w_word;

  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_word   = {r_sr[WIDTH-2:0], w_data_s};
  assign w_accept = r_rx_valid & i_rx_ready;

  // Input synchronizers plus delayed sclk for rise detection. The cs_L chain
  // resets to the deselected level so the FSM cannot leave IDLE spuriously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_data_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_L};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_spi_data};
      r_sclk_d    <= w_sclk_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: select low enters SHIFT, select high returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_cs_s) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cs_s)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: a deselect in SHIFT beats a coincident sclk rise
  always_comb begin
    w_shift_en  = 1'b0;
    w_abort     = 1'b0;
    w_word_done = 1'b0;
    if (r_state == S_SHIFT) begin
      w_abort     = w_cs_s;
      w_shift_en  = !w_cs_s && w_rise;
      w_word_done = w_shift_en && (r_bit_cnt == LAST_BIT);
    end
  end

  // Shift register and bit counter; partial words are discarded on exit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_IDLE || w_abort) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_sr      <= w_word;
      r_bit_cnt <= w_word_done ? 5'd0 : r_bit_cnt + 5'd1;
    end
  end

  // One-entry output buffer: reload on same-cycle accept, drop and flag if full
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_word_done && (!r_rx_valid || w_accept)) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
      if (w_word_done && r_rx_valid && !w_accept) r_rx_overrun <= 1'b1;
      else if (w_accept)                          r_rx_overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic r_frame_err;
  // Pulse when a frame ends with bits still pending in the shift register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_frame_err <= 1'b0;
    else         r_frame_err <= w_abort && (r_bit_cnt != 5'd0);
  end
  assign o_rx_frame_err = r_frame_err;
`endif

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_rx_overrun = r_rx_overrun;
  assign o_bit_count  = r_bit_cnt;

endmodule
